// File: rtl/sbox_serial_pkg.sv
// Shared definitions for the serial DES S-box stage: FSM encoding and
// the S-box geometry (eight boxes, 6-bit groups in, 4-bit nibbles out).
package sbox_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SBOX_N   = 8;
  localparam int GROUP_W  = 6;
  localparam int NIBBLE_W = 4;

endpackage

// File: rtl/des_sbox_rom.sv
// Combinational lookup into the eight standard DES S-boxes. This is the
// single home of the table constants; callers pick a box with sel.
module des_sbox_rom
  import sbox_serial_pkg::*;
(
  input  logic [2:0]          sel,
  input  logic [1:GROUP_W]    addr,
  output logic [1:NIBBLE_W]   data
);

  // Each 256-bit row is one box, row-major: four rows of sixteen nibbles.
  localparam logic [0:SBOX_N-1][0:63][NIBBLE_W-1:0] SBOX = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // Row is the outer bit pair {b1,b6}, column the inner four bits.
  logic [5:0] entry;

  assign entry = {addr[1], addr[6], addr[2:5]};
  assign data  = SBOX[sel][entry];

endmodule

// File: rtl/sbox_serial.sv
// Serial DES S-box substitution: one S-box per clock over the 48-bit
// E(R)^K word, producing the 32-bit S1..S8 result that feeds P.
module sbox_serial
  import sbox_serial_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:48] in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:32] out
);

  state_t             state, state_nxt;
  logic [2:0]         idx;
  logic [1:48]        work;
  logic [5:0]         base;
  logic [1:GROUP_W]   addr;
  logic [1:NIBBLE_W]  s;

  assign in_ready = (state == IDLE);

  // Group idx occupies work[6*idx+1 : 6*idx+6], highest index is 48.
  assign base = 6'(idx) * 6'd6 + 6'd1;
  assign addr = work[base +: GROUP_W];

  des_sbox_rom u_rom (
    .sel  (idx),
    .addr (addr),
    .data (s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)        state_nxt = BUSY;
      BUSY:    if (idx == 3'd7)     state_nxt = DONE;
      DONE:    if (out_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= 3'd0;
      work      <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state_nxt == DONE);
      case (state)
        IDLE: if (in_valid) begin
          work <= in;
          idx  <= 3'd0;
        end
        BUSY: begin
          out <= {out[5:32], s};
          idx <= idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_serial.sv
// Bench for sbox_serial: known-answer words pushed to a scoreboard on accept,
// popped and compared when out_valid appears.
module tb_sbox_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:48] in_w = '0;
  logic        in_ready;
  logic        out_valid;
  logic [1:32] out_w;

  logic [31:0] q[$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int acc_cyc = 0;

  sbox_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_w)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Called at a negedge with the DUT idle; returns just after the accept edge.
  task automatic accept_word(input logic [1:48] w, input logic [31:0] exp);
    in_w = w;
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL accept_ready: in_ready=%b want 1", in_ready);
    else passes++;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    q.push_back(exp);
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid; lat is the edge count after the accept edge.
  task automatic wait_result(output int lat);
    logic [31:0] exp;
    bit seen;
    seen = 0;
    lat = -1;
    for (int i = 0; i < 24 && !seen; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        seen = 1;
        lat = i;
      end
    end
    checks++;
    if (!seen) begin
      $display("FAIL result_timeout: out_valid=%b want 1 within 24 cycles", out_valid);
      if (q.size() > 0) void'(q.pop_front());
    end else begin
      exp = (q.size() > 0) ? q.pop_front() : 32'hxxxxxxxx;
      if (out_w !== exp) $display("FAIL result_data: out=%h want %h", out_w, exp);
      else passes++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else passes++;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
    else passes++;
    checks++;
    if (out_w !== 32'h0) $display("FAIL reset_out: got %h want 00000000", out_w);
    else passes++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL release_idle: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    else passes++;
  endtask

  task automatic test_zero_and_throughput();
    int lat;
    int a1;
    out_ready = 1'b1;
    accept_word(48'h0, 32'hEFA72C4D);
    a1 = acc_cyc;
    wait_result(lat);
    checks++;
    if (lat !== 8) $display("FAIL zero_latency: got %0d want 8", lat);
    else passes++;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL zero_handshake: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    else passes++;
    accept_word(48'h0, 32'hEFA72C4D);
    checks++;
    if (acc_cyc - a1 !== 10) $display("FAIL throughput: accept spacing %0d want 10", acc_cyc - a1);
    else passes++;
    wait_result(lat);
    checks++;
    if (lat !== 8) $display("FAIL zero_latency2: got %0d want 8", lat);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_ones();
    int lat;
    out_ready = 1'b1;
    accept_word(48'hFFFFFFFFFFFF, 32'hD9CE3DCB);
    wait_result(lat);
    @(negedge clk);
  endtask

  task automatic test_fips();
    int lat;
    out_ready = 1'b1;
    accept_word(48'h6117BA866527, 32'h5C82B597);
    wait_result(lat);
    checks++;
    if (lat !== 8) $display("FAIL fips_latency: got %0d want 8", lat);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    bit ok_valid, ok_data, ok_ready;
    out_ready = 1'b0;
    accept_word(48'h6117BA866527, 32'h5C82B597);
    wait_result(lat);
    in_w = 48'hFFFFFFFFFFFF;
    in_valid = 1'b1;
    ok_valid = 1; ok_data = 1; ok_ready = 1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b1) ok_valid = 0;
      if (out_w !== 32'h5C82B597) ok_data = 0;
      if (in_ready !== 1'b0) ok_ready = 0;
    end
    checks++;
    if (!ok_valid) $display("FAIL stall_valid: out_valid dropped, last %b want 1", out_valid);
    else passes++;
    checks++;
    if (!ok_data) $display("FAIL stall_data: out=%h want 5c82b597", out_w);
    else passes++;
    checks++;
    if (!ok_ready) $display("FAIL stall_in_ready: in_ready=%b want 0", in_ready);
    else passes++;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL stall_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    else passes++;
    // in_valid is still high: exactly one new word goes in on this edge.
    @(posedge clk);
    #1;
    q.push_back(32'hD9CE3DCB);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL held_accept: in_ready=%b want 0", in_ready);
    else passes++;
    wait_result(lat);
    checks++;
    if (lat !== 8) $display("FAIL held_latency: got %0d want 8", lat);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_reset_midbusy();
    int lat;
    out_ready = 1'b1;
    in_w = 48'h6117BA866527;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL midbusy_ctrl: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    else passes++;
    checks++;
    if (out_w !== 32'h0) $display("FAIL midbusy_out: got %h want 00000000", out_w);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    accept_word(48'h0, 32'hEFA72C4D);
    wait_result(lat);
    checks++;
    if (lat !== 8) $display("FAIL midbusy_latency: got %0d want 8", lat);
    else passes++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_zero_and_throughput();
    test_ones();
    test_fips();
    test_backpressure();
    test_reset_midbusy();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
